dqsw_wrlvl_trainer: RTL and testbench



---
 rtl/ddr3_train_pkg.sv | 22 ++
 rtl/dqsw_fb_filter.sv | 44 ++++
 rtl/dqsw_wrlvl_trainer.sv | 142 ++++++++++++++
 tb/tb_dqsw_wrlvl_trainer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_train_pkg.sv
// rtl/ddr3_train_pkg.sv - shared types and constants for DDR3 write-leveling training
package ddr3_train_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PULSE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_MOVE,
    ST_DONE,
    ST_FAIL
  } train_state_t;

  localparam logic [1:0] DQS_PULSE = 2'b01;
  localparam logic [1:0] DQS_OE_ON = 2'b11;
  localparam logic [1:0] DQS_OFF   = 2'b00;

  localparam int DEF_MAX_TAPS      = 128;
  localparam int DEF_SETTLE_CYCLES = 16;

endpackage

// File: rtl/dqsw_fb_filter.sv
// rtl/dqsw_fb_filter.sv - DQ feedback filter: pass-through, or 2-of-3 vote with DQSW_WRLVL_MAJORITY_EN
module dqsw_fb_filter
  import ddr3_train_pkg::*;
(
`ifdef DQSW_WRLVL_MAJORITY_EN
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
`endif
  input  logic i_strobe,
  input  logic i_fb,
  output logic o_valid,
  output logic o_fb
);

`ifdef DQSW_WRLVL_MAJORITY_EN
  logic [1:0] r_vote_cnt;
  logic [1:0] r_samples;

  // First two samples are stored; the third completes the vote combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vote_cnt <= 2'd0;
      r_samples  <= 2'b00;
    end else if (i_clear) begin
      r_vote_cnt <= 2'd0;
    end else if (i_strobe) begin
      if (r_vote_cnt == 2'd2) begin
        r_vote_cnt <= 2'd0;
      end else begin
        r_samples[r_vote_cnt[0]] <= i_fb;
        r_vote_cnt               <= r_vote_cnt + 2'd1;
      end
    end
  end

  assign o_valid = i_strobe && (r_vote_cnt == 2'd2);
  assign o_fb    = (r_samples[0] & r_samples[1]) | (r_samples[0] & i_fb) | (r_samples[1] & i_fb);
`else
  assign o_valid = i_strobe;
  assign o_fb    = i_fb;
`endif

endmodule

// File: rtl/dqsw_wrlvl_trainer.sv
// rtl/dqsw_wrlvl_trainer.sv - DDR3 byte-lane write-leveling DQSW sweep; DQSW_WRLVL_MAJORITY_EN enables 2-of-3 voting
module dqsw_wrlvl_trainer
  import ddr3_train_pkg::*;
#(
  parameter int MAX_TAPS      = DEF_MAX_TAPS,
  parameter int TAP_W         = 8,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = 5
) (
  input  logic             FAB_CLK,
  input  logic             ARST_N,
  input  logic             train_start,
  output logic             train_busy,
  output logic             train_done,
  output logic             train_fail,
  output logic [TAP_W-1:0] tap_value,
  output logic [1:0]       TX_DATA_0,
  output logic [1:0]       OE_DATA_0,
  input  logic [1:0]       RX_DATA_0,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0,
  output logic             ODT_EN_0
);

  train_state_t     r_state;
  logic [TAP_W-1:0] r_tap;
  logic [CNT_W-1:0] r_settle;
  logic             r_seen_low;
  logic             r_busy, r_done, r_fail, r_load, r_move, r_dir;
  logic [1:0]       r_tx, r_oe;
  logic             w_fb, w_fb_valid, w_fb_filt, w_sample, w_idle_like;

  // A split 01/10 readback means the edge is mid-transition; treat it as not yet high.
  assign w_fb        = RX_DATA_0[1] & RX_DATA_0[0];
  assign w_sample    = (r_state == ST_SAMPLE);
  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_FAIL);

  dqsw_fb_filter u_fb_filter (
`ifdef DQSW_WRLVL_MAJORITY_EN
    .clk      (FAB_CLK),
    .rst_n    (ARST_N),
    .i_clear  (w_idle_like),
`endif
    .i_strobe (w_sample),
    .i_fb     (w_fb),
    .o_valid  (w_fb_valid),
    .o_fb     (w_fb_filt)
  );

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_state    <= ST_IDLE;
      r_tap      <= '0;
      r_settle   <= '0;
      r_seen_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      r_load     <= 1'b0;
      r_move     <= 1'b0;
      r_dir      <= 1'b0;
      r_tx       <= DQS_OFF;
      r_oe       <= DQS_OFF;
    end else begin
      r_load <= 1'b0;
      r_move <= 1'b0;
      r_tx   <= DQS_OFF;
      r_oe   <= DQS_OFF;
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (train_start) begin
            r_state    <= ST_LOAD;
            r_tap      <= '0;
            r_seen_low <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_busy     <= 1'b1;
            r_dir      <= 1'b1;
            r_load     <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_state <= ST_PULSE;
          r_tx    <= DQS_PULSE;
          r_oe    <= DQS_OE_ON;
        end
        ST_PULSE: begin
          r_state  <= ST_SETTLE;
          r_settle <= CNT_W'(SETTLE_CYCLES - 1);
        end
        ST_SETTLE: begin
          if (r_settle == '0) r_state <= ST_SAMPLE;
          else                r_settle <= r_settle - 1'b1;
        end
        ST_SAMPLE: begin
          if (!w_fb_valid) begin
            r_state <= ST_PULSE;
            r_tx    <= DQS_PULSE;
            r_oe    <= DQS_OE_ON;
          end else if (w_fb_filt && r_seen_low) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_dir   <= 1'b0;
          end else begin
            if (!w_fb_filt) r_seen_low <= 1'b1;
            if ((r_tap == TAP_W'(MAX_TAPS - 1)) || DELAY_LINE_OUT_OF_RANGE_0) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
              r_dir   <= 1'b0;
            end else begin
              r_state <= ST_MOVE;
              r_move  <= 1'b1;
            end
          end
        end
        ST_MOVE: begin
          r_state <= ST_PULSE;
          r_tap   <= r_tap + 1'b1;
          r_tx    <= DQS_PULSE;
          r_oe    <= DQS_OE_ON;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign train_busy             = r_busy;
  assign train_done             = r_done;
  assign train_fail             = r_fail;
  assign tap_value              = r_tap;
  assign TX_DATA_0              = r_tx;
  assign OE_DATA_0              = r_oe;
  assign DELAY_LINE_LOAD_0      = r_load;
  assign DELAY_LINE_MOVE_0      = r_move;
  assign DELAY_LINE_DIRECTION_0 = r_dir;
  assign ODT_EN_0               = 1'b0;

endmodule

// File: tb/tb_dqsw_wrlvl_trainer.sv
// tb/tb_dqsw_wrlvl_trainer.sv - randomized self-checking bench for dqsw_wrlvl_trainer
module tb_dqsw_wrlvl_trainer;

  localparam int MAX_TAPS = 128;
  localparam int SETTLE   = 16;
`ifdef DQSW_WRLVL_MAJORITY_EN
  localparam bit MAJ = 1'b1;
`else
  localparam bit MAJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       train_start = 1'b0;
  logic       busy, done, fail;
  logic [7:0] tap;
  logic [1:0] tx, oe;
  logic [1:0] rx = 2'b00;
  logic       dl_load, dl_move, dl_dir, odt;
  logic       oor = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  bit fb_tab [0:MAX_TAPS-1][0:2];
  int oor_from = 1000;
  int model_tap = 0, rep = 0, cur_rep = 0, since = 1000;
  int n_moves = 0, n_loads = 0, n_bad = 0;
  logic [1:0] prev_tx = 2'b00;
  logic prev_load = 1'b0, prev_move = 1'b0;

  always #5 clk = ~clk;

  dqsw_wrlvl_trainer dut (
    .FAB_CLK                   (clk),
    .ARST_N                    (rst_n),
    .train_start               (train_start),
    .train_busy                (busy),
    .train_done                (done),
    .train_fail                (fail),
    .tap_value                 (tap),
    .TX_DATA_0                 (tx),
    .OE_DATA_0                 (oe),
    .RX_DATA_0                 (rx),
    .DELAY_LINE_LOAD_0         (dl_load),
    .DELAY_LINE_MOVE_0         (dl_move),
    .DELAY_LINE_DIRECTION_0    (dl_dir),
    .DELAY_LINE_OUT_OF_RANGE_0 (oor),
    .ODT_EN_0                  (odt)
  );

  function automatic logic [1:0] enc(input bit b);
    logic [1:0] v;
    if (b) return 2'b11;
    v = 2'($urandom_range(0, 2));
    return v;
  endfunction

  // Delay-line + DRAM model: tracks its own tap from LOAD/MOVE pulses and only
  // presents the true feedback exactly SETTLE+1 cycles after each DQS pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_tap = 0; rep = 0; since = 1000;
      prev_tx = 2'b00; prev_load = 1'b0; prev_move = 1'b0;
    end else begin
      if (dl_load) begin n_loads++; model_tap = 0; rep = 0; end
      if (dl_move) begin n_moves++; if (dl_dir !== 1'b1) n_bad++; model_tap++; rep = 0; end
      if ((dl_load && prev_load) || (dl_move && prev_move)) n_bad++;
      if (tx == 2'b01) begin
        if (oe !== 2'b11 || prev_tx == 2'b01) n_bad++;
        since = 0; cur_rep = (rep > 2) ? 2 : rep; rep++;
      end else begin
        if (oe !== 2'b00 || tx !== 2'b00) n_bad++;
        if (since < 1000) since++;
      end
      if (odt !== 1'b0) n_bad++;
      prev_tx = tx; prev_load = dl_load; prev_move = dl_move;
      oor = (model_tap >= oor_from);
      if (model_tap < MAX_TAPS)
        rx = enc((since == SETTLE + 1) ? fb_tab[model_tap][cur_rep] : !fb_tab[model_tap][cur_rep]);
    end
  end

  function automatic void ref_model(output bit e_done, output int e_tap);
    bit seen = 1'b0;
    bit f;
    e_done = 1'b0; e_tap = 0;
    for (int t = 0; t < MAX_TAPS; t++) begin
      if (MAJ) f = (int'(fb_tab[t][0]) + int'(fb_tab[t][1]) + int'(fb_tab[t][2])) >= 2;
      else     f = fb_tab[t][0];
      if (f && seen) begin e_done = 1'b1; e_tap = t; return; end
      if (!f) seen = 1'b1;
      if (t == MAX_TAPS - 1 || t >= oor_from) begin e_tap = t; return; end
    end
  endfunction

  function automatic void fill_edge(input int lo_start, input int hi_start);
    for (int t = 0; t < MAX_TAPS; t++)
      for (int r = 0; r < 3; r++)
        fb_tab[t][r] = (t < lo_start) || (t >= hi_start);
  endfunction

  task automatic start_pulse();
    @(negedge clk) train_start = 1'b1;
    @(negedge clk) train_start = 1'b0;
  endtask

  task automatic run_sweep();
    int c = 0;
    n_moves = 0; n_loads = 0; n_bad = 0;
    start_pulse();
    while (!(done || fail) && c < 20000) begin @(negedge clk); c++; end
    n_checks++;
    if (c >= 20000) begin n_fail++; $display("FAIL sweep_timeout: waited %0d cycles, required done or fail", c); end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({busy, done, fail, tap, tx, oe, dl_load, dl_move, dl_dir, odt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got busy=%b done=%b fail=%b tap=%0d tx=%b oe=%b, required all 0", busy, done, fail, tap, tx, oe);
    end
  endtask

  task automatic test_expect(input string name, input bit e_done, input int e_tap);
    n_checks++;
    if (done !== e_done || fail !== !e_done || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_status: done=%b fail=%b busy=%b, required done=%b fail=%b", name, done, fail, busy, e_done, !e_done);
    end
    n_checks++;
    if (tap !== 8'(e_tap)) begin n_fail++; $display("FAIL %s_tap: got %0d required %0d", name, tap, e_tap); end
    n_checks++;
    if (n_moves != e_tap || n_loads != 1) begin
      n_fail++; $display("FAIL %s_pulses: moves=%0d loads=%0d required moves=%0d loads=1", name, n_moves, n_loads, e_tap);
    end
    n_checks++;
    if (n_bad != 0) begin n_fail++; $display("FAIL %s_protocol: %0d pattern/pulse violations, required 0", name, n_bad); end
  endtask

  task automatic test_lock_37();
    bit ed; int et;
    oor_from = 1000; fill_edge(0, 37);
    ref_model(ed, et);
    run_sweep();
    test_expect("lock37", ed, et);
    n_checks++;
    if (!(ed && et == 37)) begin n_fail++; $display("FAIL lock37_ref: model gave done=%b tap=%0d required 1/37", ed, et); end
  endtask

  task automatic test_relock_20();
    bit ed; int et;
    oor_from = 1000; fill_edge(10, 20);
    ref_model(ed, et);
    run_sweep();
    test_expect("relock20", 1'b1, 20);
  endtask

  task automatic test_stuck_low();
    oor_from = 1000; fill_edge(0, 1000);
    run_sweep();
    test_expect("stuck_low", 1'b0, 127);
  endtask

  task automatic test_out_of_range();
    oor_from = 50; fill_edge(0, 1000);
    run_sweep();
    test_expect("oor50", 1'b0, 50);
  endtask

  task automatic test_random();
    bit ed; int et;
    for (int i = 0; i < 5; i++) begin
      oor_from = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 127)) : 1000;
      for (int t = 0; t < MAX_TAPS; t++)
        for (int r = 0; r < 3; r++)
          fb_tab[t][r] = ($urandom_range(0, 99) < ((t < 8) ? 50 : 12));
      ref_model(ed, et);
      run_sweep();
      test_expect($sformatf("random%0d", i), ed, et);
    end
  endtask

  task automatic test_busy_start();
    int c = 0;
    oor_from = 1000; fill_edge(0, 30);
    n_moves = 0; n_loads = 0; n_bad = 0;
    start_pulse();
    repeat (200) @(negedge clk);
    start_pulse();
    while (!(done || fail) && c < 20000) begin @(negedge clk); c++; end
    test_expect("busy_start", 1'b1, 30);
  endtask

  task automatic test_reset_mid();
    int c = 0;
    oor_from = 1000; fill_edge(0, 1000);
    start_pulse();
    while (model_tap != 12 && c < 5000) begin @(negedge clk); c++; end
    n_checks++;
    if (c >= 5000) begin n_fail++; $display("FAIL reset_mid_reach: model tap %0d, required 12", model_tap); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, fail, tap, tx, oe, dl_load, dl_move, dl_dir} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: busy=%b tap=%0d tx=%b oe=%b load=%b move=%b, required all 0", busy, tap, tx, oe, dl_load, dl_move);
    end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    fill_edge(0, 37);
    run_sweep();
    test_expect("restart", 1'b1, 37);
  endtask

`ifdef DQSW_WRLVL_MAJORITY_EN
  task automatic test_majority();
    oor_from = 1000; fill_edge(0, 5);
    fb_tab[5][0] = 1'b1; fb_tab[5][1] = 1'b0; fb_tab[5][2] = 1'b0;
    fb_tab[6][0] = 1'b1; fb_tab[6][1] = 1'b1; fb_tab[6][2] = 1'b0;
    run_sweep();
    test_expect("majority", 1'b1, 6);
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_lock_37();
    test_relock_20();
    test_stuck_low();
    test_out_of_range();
    test_busy_start();
    test_reset_mid();
`ifdef DQSW_WRLVL_MAJORITY_EN
    test_majority();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
